// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle sequencing controller:
// state encoding, opcodes, ALU codes and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWR   = 4'd4,
        S_MEMWB   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_ADDIEX  = 4'd8,
        S_ADDIWB  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } mc_state_t;

    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_LW    = 3'b001;
    localparam logic [2:0] OP_SW    = 3'b010;
    localparam logic [2:0] OP_BEQ   = 3'b011;
    localparam logic [2:0] OP_ADDI  = 3'b100;
    localparam logic [2:0] OP_J     = 3'b101;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_outdec.sv
// Combinational state-to-control-word decoder for mc_controller.
// With MC_CONTROLLER_ILLEGAL_TRAP_EN defined, also drives the illegal flag.
import mc_pkg::*;

module mc_outdec (
    input  logic [3:0] state,
    input  logic [3:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcwrite,
    output logic       branch,
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic [3:0] alucontrol
);

    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        pcsrc      = PC_ALU;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        alucontrol = ALU_ADD;
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
        illegal    = 1'b0;
`endif
        case (mc_state_t'(state))
            S_FETCH: begin
                // PC+1 and IR load only commit once memory has returned the word
                mem_req = 1'b1;
                alusrcb = SRCB_ONE;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMM;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = funct;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                branch     = 1'b1;
                pcsrc      = PC_ALUOUT;
            end
            S_JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = PC_JUMP;
            end
            S_ILLEGAL: begin
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
                illegal = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore sequencing controller for the 16-bit MIPS-style CPU.
// MC_CONTROLLER_ILLEGAL_TRAP_EN makes opcodes 110/111 trap until reset.
//
// state     | meaning
// FETCH     | read instruction at PC, PC <= PC+1 on mem_ready
// DECODE    | register read, branch target into ALUOut
// MEMADR    | lw/sw address = A + signext imm
// MEMRD     | load read, wait for mem_ready
// MEMWR     | store write, wait for mem_ready
// MEMWB     | rt <= MDR
// EXECUTE   | R-type ALU op from funct
// ALUWB     | rd <= ALUOut
// ADDIEX    | A + signext imm
// ADDIWB    | rt <= ALUOut
// BRANCH    | compare A-B, PC <= ALUOut if zero
// JUMP      | PC <= jump target
// ILLEGAL   | undefined opcode: NOP, or terminal trap
import mc_pkg::*;

module mc_controller #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   op,
    input  logic [3:0]   funct,
    input  logic         zero,
    input  logic         mem_ready,
    output logic         mem_req,
    output logic         iord,
    output logic         memwrite,
    output logic         irwrite,
    output logic         regdst,
    output logic         memtoreg,
    output logic         regwrite,
    output logic         alusrca,
    output logic [1:0]   alusrcb,
    output logic [1:0]   pcsrc,
    output logic         pcen,
    output logic [3:0]   alucontrol,
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
    output logic         illegal,
`endif
    output logic [n-1:0] instret
);

    mc_state_t state_q;
    mc_state_t state_d;
    logic      retire;

    logic mem_req_raw;
    logic memwrite_raw;
    logic irwrite_raw;
    logic regwrite_raw;
    logic pcwrite;
    logic branch;
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
    logic illegal_raw;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
            S_ILLEGAL: state_d = S_ILLEGAL;
`else
            S_ILLEGAL: state_d = S_FETCH;
`endif
            default:   state_d = S_FETCH;
        endcase
    end

    // An instruction retires on the edge that brings the FSM back to FETCH
    assign retire = (state_q != S_FETCH) && (state_d == S_FETCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + {{(n-1){1'b0}}, 1'b1};
        end
    end

    mc_outdec u_outdec (
        .state      (state_q),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req_raw),
        .iord       (iord),
        .memwrite   (memwrite_raw),
        .irwrite    (irwrite_raw),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite_raw),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .pcwrite    (pcwrite),
        .branch     (branch),
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
        .illegal    (illegal_raw),
`endif
        .alucontrol (alucontrol)
    );

    // Side-effecting strobes are squashed while reset is held, even mid-access
    assign mem_req  = mem_req_raw  & ~reset;
    assign memwrite = memwrite_raw & ~reset;
    assign irwrite  = irwrite_raw  & ~reset;
    assign regwrite = regwrite_raw & ~reset;
    assign pcen     = (pcwrite | (branch & zero)) & ~reset;
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
    assign illegal  = illegal_raw & ~reset;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction behavioural model
// (cycle count and per-strobe activity totals) under random memory stalls.
module tb_mc_controller;

    localparam int N = 8;

    localparam logic [2:0] T_R    = 3'b000;
    localparam logic [2:0] T_LW   = 3'b001;
    localparam logic [2:0] T_SW   = 3'b010;
    localparam logic [2:0] T_BEQ  = 3'b011;
    localparam logic [2:0] T_ADDI = 3'b100;
    localparam logic [2:0] T_J    = 3'b101;
    localparam logic [2:0] T_ILL  = 3'b110;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   op;
    logic [3:0]   funct;
    logic         zero;
    logic         mem_ready;
    logic         mem_req;
    logic         iord;
    logic         memwrite;
    logic         irwrite;
    logic         regdst;
    logic         memtoreg;
    logic         regwrite;
    logic         alusrca;
    logic [1:0]   alusrcb;
    logic [1:0]   pcsrc;
    logic         pcen;
    logic [3:0]   alucontrol;
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
    logic         illegal;
`endif
    logic [N-1:0] instret;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_controller #(.n(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .alucontrol (alucontrol),
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
        .illegal    (illegal),
`endif
        .instret    (instret)
    );

    function automatic bit is_mem(input logic [2:0] o);
        return (o == T_LW) || (o == T_SW);
    endfunction

    // Instruction length with a ready memory, plus one cycle per stall
    function automatic int exp_cycles(input logic [2:0] o, input int fs, input int ms);
        int base;
        case (o)
            T_R:     base = 4;
            T_LW:    base = 5;
            T_SW:    base = 4;
            T_BEQ:   base = 3;
            T_ADDI:  base = 4;
            T_J:     base = 3;
            default: base = 3;
        endcase
        return base + fs + (is_mem(o) ? ms : 0);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one instruction from FETCH to retirement, playing a memory that
    // stalls fs cycles on the fetch and ms cycles on the data access.
    task automatic run_instr(input logic [2:0] o, input logic [3:0] f, input logic z,
                             input int fs, input int ms);
        logic [N-1:0] start;
        logic [N-1:0] exp_ir;
        int cyc, acc, waited, post, stall;
        int n_irw, n_regw, n_memw, n_pcen, n_req, n_m2r, n_alu;
        int e_regw, e_memw, e_pcen, e_req, e_m2r;
        bit done, keep;
        start = instret;
        exp_ir = start + N'(1);
        cyc = 0; acc = 0; waited = 0; post = 0; done = 1'b0;
        n_irw = 0; n_regw = 0; n_memw = 0; n_pcen = 0; n_req = 0; n_m2r = 0; n_alu = 0;
        while (!done && cyc < 60) begin
            keep  = (acc >= 1) && ((post == 0) || (post == 1 && is_mem(o)));
            op    = keep ? o : 3'($urandom);
            funct = f;
            zero  = (o == T_BEQ) ? z : 1'($urandom);
            if (mem_req) begin
                stall = (acc == 0) ? fs : ms;
                if (waited < stall) begin
                    mem_ready = 1'b0;
                    waited++;
                end else begin
                    mem_ready = 1'b1;
                end
            end else begin
                mem_ready = 1'($urandom);
            end
            #1;
            n_irw  += int'(irwrite);
            n_regw += int'(regwrite);
            n_memw += int'(memwrite);
            n_pcen += int'(pcen);
            n_req  += int'(mem_req);
            n_m2r  += int'(regwrite && memtoreg && !regdst);
            n_alu  += int'(alusrca && alusrcb == 2'b00 && alucontrol == f);
            if (acc >= 1) post++;
            if (mem_req && mem_ready) begin
                acc++;
                waited = 0;
            end
            cyc++;
            @(posedge clk);
            #1;
            if (instret !== start) done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL retire_timeout op=%0d: instret stayed %0d after %0d cycles", o, start, cyc);
            return;
        end
        e_regw = (o == T_R || o == T_LW || o == T_ADDI) ? 1 : 0;
        e_memw = (o == T_SW) ? ms + 1 : 0;
        e_pcen = 1 + ((o == T_J) ? 1 : 0) + ((o == T_BEQ && z) ? 1 : 0);
        e_req  = fs + 1 + (is_mem(o) ? ms + 1 : 0);
        e_m2r  = (o == T_LW) ? 1 : 0;
        checks++;
        if (cyc !== exp_cycles(o, fs, ms)) begin
            failures++;
            $display("FAIL cycles op=%0d fs=%0d ms=%0d: got %0d expected %0d", o, fs, ms, cyc, exp_cycles(o, fs, ms));
        end
        checks++;
        if (instret !== exp_ir) begin
            failures++;
            $display("FAIL instret op=%0d: got %0d expected %0d", o, instret, exp_ir);
        end
        checks++;
        if (n_irw !== 1) begin
            failures++;
            $display("FAIL irwrite_pulses op=%0d: got %0d expected 1", o, n_irw);
        end
        checks++;
        if (n_regw !== e_regw) begin
            failures++;
            $display("FAIL regwrite_cycles op=%0d: got %0d expected %0d", o, n_regw, e_regw);
        end
        checks++;
        if (n_memw !== e_memw) begin
            failures++;
            $display("FAIL memwrite_cycles op=%0d: got %0d expected %0d", o, n_memw, e_memw);
        end
        checks++;
        if (n_pcen !== e_pcen) begin
            failures++;
            $display("FAIL pcen_cycles op=%0d z=%0d: got %0d expected %0d", o, z, n_pcen, e_pcen);
        end
        checks++;
        if (n_req !== e_req) begin
            failures++;
            $display("FAIL mem_req_cycles op=%0d: got %0d expected %0d", o, n_req, e_req);
        end
        checks++;
        if (n_m2r !== e_m2r) begin
            failures++;
            $display("FAIL mdr_writeback op=%0d: got %0d expected %0d", o, n_m2r, e_m2r);
        end
        if (o == T_R) begin
            checks++;
            if (n_alu < 1) begin
                failures++;
                $display("FAIL rtype_alucontrol funct=%0h: got %0d execute cycles expected 1", f, n_alu);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op = T_R; funct = 4'h0; zero = 1'b1; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({mem_req, memwrite, irwrite, regwrite, pcen} !== 5'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 00000", {mem_req, memwrite, irwrite, regwrite, pcen});
        end
        checks++;
        if (instret !== '0) begin
            failures++;
            $display("FAIL reset_instret: got %0d expected 0", instret);
        end
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
        checks++;
        if (illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_illegal: got %b expected 0", illegal);
        end
`endif
        reset = 1'b0;
        #1;
        checks++;
        if (!(mem_req === 1'b1 && iord === 1'b0 && alusrcb === 2'b01 && irwrite === 1'b1)) begin
            failures++;
            $display("FAIL reset_fetch: mem_req=%b iord=%b alusrcb=%b irwrite=%b expected 1 0 01 1",
                     mem_req, iord, alusrcb, irwrite);
        end
    endtask

    task automatic test_rtype();
        run_instr(T_R, 4'h3, 1'b0, 0, 0);
        checks++;
        if (instret !== N'(1)) begin
            failures++;
            $display("FAIL rtype_first_retire: got %0d expected 1", instret);
        end
    endtask

    task automatic test_lw_stall();
        run_instr(T_LW, 4'h0, 1'b0, 2, 2);
    endtask

    task automatic test_beq();
        run_instr(T_BEQ, 4'h0, 1'b1, 0, 0);
        run_instr(T_BEQ, 4'h0, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        logic [2:0] o;
        for (int i = 0; i < 40; i++) begin
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
            o = 3'($urandom_range(0, 5));
`else
            o = 3'($urandom_range(0, 7));
`endif
            run_instr(o, 4'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    task automatic test_illegal();
`ifdef MC_CONTROLLER_ILLEGAL_TRAP_EN
        logic [N-1:0] start;
        start = instret;
        op = T_ILL; mem_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom);
            mem_ready = 1'($urandom);
            zero = 1'($urandom);
            #1;
            checks++;
            if (!(illegal === 1'b1 && {mem_req, memwrite, irwrite, regwrite, pcen} === 5'b0
                  && instret === start)) begin
                failures++;
                $display("FAIL trap_stuck cycle %0d: illegal=%b strobes=%b instret=%0d expected 1 00000 %0d",
                         i, illegal, {mem_req, memwrite, irwrite, regwrite, pcen}, instret, start);
            end
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (illegal !== 1'b0) begin
            failures++;
            $display("FAIL trap_reset_illegal: got %b expected 0", illegal);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (!(mem_req === 1'b1 && iord === 1'b0 && illegal === 1'b0)) begin
            failures++;
            $display("FAIL trap_exit_fetch: mem_req=%b iord=%b illegal=%b expected 1 0 0", mem_req, iord, illegal);
        end
        @(negedge clk);
`else
        run_instr(T_ILL, 4'h0, 1'b0, 0, 0);
        run_instr(3'b111, 4'h0, 1'b0, 1, 0);
`endif
    endtask

    task automatic test_sw_reset();
        bit seen;
        run_instr(T_ADDI, 4'h0, 1'b0, 0, 0);
        op = T_SW; funct = 4'h0; zero = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            mem_ready = 1'b1;
            #1;
            if (memwrite) begin
                mem_ready = 1'b0;
                seen = 1'b1;
            end else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL sw_reach_memwr: memwrite=%b expected 1 within 10 cycles", memwrite);
            return;
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (!(memwrite === 1'b1 && mem_req === 1'b1 && iord === 1'b1)) begin
                failures++;
                $display("FAIL sw_hold stall %0d: memwrite=%b mem_req=%b iord=%b expected 1 1 1",
                         i, memwrite, mem_req, iord);
            end
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (!(memwrite === 1'b0 && mem_req === 1'b0)) begin
            failures++;
            $display("FAIL sw_reset_drop: memwrite=%b mem_req=%b expected 0 0", memwrite, mem_req);
        end
        @(posedge clk);
        #1;
        checks++;
        if (instret !== '0) begin
            failures++;
            $display("FAIL sw_reset_instret: got %0d expected 0", instret);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (!(mem_req === 1'b1 && iord === 1'b0 && alusrcb === 2'b01 && memwrite === 1'b0)) begin
            failures++;
            $display("FAIL sw_reset_fetch: mem_req=%b iord=%b alusrcb=%b memwrite=%b expected 1 0 01 0",
                     mem_req, iord, alusrcb, memwrite);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < (1 << N); i++) begin
            run_instr(T_J, 4'h0, 1'b0, 0, 0);
            if (i == (1 << N) - 2) begin
                checks++;
                if (instret !== {N{1'b1}}) begin
                    failures++;
                    $display("FAIL wrap_max: got %0h expected %0h", instret, {N{1'b1}});
                end
            end
        end
        checks++;
        if (instret !== '0) begin
            failures++;
            $display("FAIL wrap_zero: got %0h expected 0", instret);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_random();
        test_illegal();
        test_sw_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle sequencing controller for the 16-bit MIPS-style CPU. Replaces single-cycle control with a Moore FSM that steps one instruction through fetch, decode, execute, memory and writeback over 3–5 cycles. It drives a shared-memory multicycle datapath and stalls on a memory ready handshake. Control from the current instruction's op/funct is regenerated every cycle from the registered state.

## Interface
- `n`, default 16: datapath width; used only for the retired-instruction counter.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 3: opcode from the instruction register.
- `funct` in 4: function field from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completed the current access this cycle.
- `mem_req` out 1: memory access request.
- `iord` out 1: memory address source; 0 = PC, 1 = ALUOut.
- `memwrite` out 1: memory write strobe.
- `irwrite` out 1: instruction register load.
- `regdst` out 1: destination register select; 1 = rd.
- `memtoreg` out 1: writeback source; 1 = memory data register (MDR).
- `regwrite` out 1: register file write.
- `alusrca` out 1: ALU A input; 0 = PC, 1 = register A.
- `alusrcb` out 2: ALU B input; 00 = B, 01 = const 1, 10 = signext immediate.
- `pcsrc` out 2: next-PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pcen` out 1: PC load, equal to pcwrite | (branch & zero).
- `alucontrol` out 4: ALU operation.
- `illegal` out 1: illegal-opcode trap flag. Present only with the trap macro.
- `instret` out n: retired-instruction count.

## Operation
- Opcodes:
  - 000 R-type
  - 001 lw
  - 010 sw
  - 011 beq
  - 100 addi
  - 101 j
  - 110 and 111 illegal
- States and transitions:
  - FETCH → DECODE. Waits in FETCH while !mem_ready.
  - DECODE → MEMADR for lw/sw, EXECUTE for R-type, BRANCH for beq, ADDIEX for addi, JUMP for j, ILLEGAL for 110/111.
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD: waits for mem_ready, then → MEMWB.
  - MEMWR: waits for mem_ready, then → FETCH.
  - EXECUTE → ALUWB.
  - ADDIEX → ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00. irwrite and pcwrite are asserted only in the cycle where mem_ready=1.
- DECODE: alusrca=0, alusrcb=10, add. Precomputes the branch target into ALUOut.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10, add.
- MEMRD: mem_req=1, iord=1.
- MEMWR: mem_req=1, iord=1, memwrite=1. memwrite is held for the whole wait.
- MEMWB: regwrite=1, memtoreg=1, regdst=0.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol=funct.
- ALUWB: regwrite=1, regdst=1, memtoreg=0.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0.
- BRANCH: alusrca=1, alusrcb=00, sub, branch=1, pcsrc=01.
- JUMP: pcwrite=1, pcsrc=10.
- Outputs not listed for a state are 0. alucontrol defaults to ALU_ADD.
- instret increments by 1 on every transition into FETCH from a non-FETCH state. It wraps modulo 2^n.
- op is sampled only in DECODE and MEMADR. Changes in other states are ignored.

## Timing
- Cycle counts with mem_ready always 1:
  - R-type 4
  - lw 5
  - sw 4
  - beq 3
  - addi 4
  - j 3
- Each wait cycle on mem_ready adds 1 cycle.
- All outputs are combinational from the registered state, plus mem_ready and zero where noted above. No input-to-state combinational loop.
- While reset=1:
  - state ← FETCH and instret ← 0 at the clock edge.
  - mem_req, memwrite, irwrite, regwrite and pcen are forced to 0 in the same cycle.
  - illegal is 0.
- Reset mid-instruction, including a stalled MEMWR: the instruction is abandoned without retiring. The first cycle after reset deasserts is FETCH.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- In BRANCH with zero=0: pcen=0 and the PC is held.

## Configuration
- `MC_CONTROLLER_ILLEGAL_TRAP_EN` defined:
  - ILLEGAL is a terminal state with illegal=1 and all write enables 0.
  - Only reset exits ILLEGAL. It does not increment instret.
- Macro undefined:
  - The `illegal` port is absent.
  - ILLEGAL behaves as a 1-cycle NOP → FETCH and increments instret.

## Structure
- Package `mc_pkg` holds:
  - State enum `mc_state_t`, 4 bits.
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - ALU codes ALU_ADD=4'h0, ALU_SUB=4'h1.
- One sub-module: `mc_outdec`, a combinational state-to-control-word decoder.
- The state register, next-state logic and instret counter stay in `mc_controller`.

## Test plan
- Reset held 2 cycles, then R-type funct=4'h3 with mem_ready=1: states FETCH, DECODE, EXECUTE (alucontrol=4'h3), ALUWB (regwrite=1, regdst=1), then FETCH; instret=1.
- lw with mem_ready low for 2 cycles in both FETCH and MEMRD: 9 total cycles; irwrite pulses exactly once; regwrite=1 with memtoreg=1 in MEMWB.
- beq with zero=1: pcen=1 and pcsrc=01 in cycle 3. Repeat with zero=0: pcen=0; both retire in 3 cycles.
- sw stalled 3 cycles in MEMWR, then reset=1: memwrite drops in the reset cycle; FETCH follows; instret=0.
- op=3'b110 with the trap macro: illegal=1 and the FSM is stuck for 10 cycles until reset. Without the macro: back to FETCH after 1 cycle; instret increments.
- 2^16 j instructions with n=16: instret wraps from 16'hFFFF to 16'h0000.
